// File: rtl/modulo_counter_pkg.sv
// Shared definitions for the modulo_counter slice: direction encodings, default
// sizing and the per-edge operation decode used by the counter.
package modulo_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int          DEFAULT_WIDTH     = 32;
  localparam logic [31:0] DEFAULT_MAX_COUNT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STEP  = 2'd3
  } op_e;

endpackage

// File: rtl/count_prescaler.sv
// Enabled-cycle prescaler: emits a one-cycle step tick on every PRESCALE_DIV-th
// enabled cycle. Only instantiated when COUNTER_PRESCALER_EN is defined.
module count_prescaler #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/modulo_counter.sv
// Up/down modulo counter with clear, saturating parallel load, terminal-count
// pulse and sticky wrap flag. Define COUNTER_PRESCALER_EN to add the step prescaler.
module modulo_counter
  import modulo_counter_pkg::*;
#(
  parameter int          WIDTH        = DEFAULT_WIDTH,
  parameter logic [31:0] MAX_COUNT    = DEFAULT_MAX_COUNT,
  parameter logic [31:0] RESET_VALUE  = 32'd0,
  parameter int          PRESCALE_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             wrap_clr,
  output logic [WIDTH-1:0] counting,
  output logic             terminal_count,
  output logic             wrap_sticky
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE_DIV < 1 || RST_V > MAX_V) begin : g_bad_param
    $error("modulo_counter: illegal parameter combination");
  end

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  logic             step;
  op_e              op;
  logic             wrap;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             sticky_q, sticky_d;

`ifdef COUNTER_PRESCALER_EN
  count_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .clear (clear | load),
    .tick  (step)
  );
`else
  assign step = enable;
`endif

  always_comb begin
    op = OP_HOLD;
    if (clear) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (step) begin
      op = OP_STEP;
    end
  end

  // Next-state: only a step can wrap, so clear/load never pulse terminal_count.
  always_comb begin
    cnt_d    = cnt_q;
    wrap     = 1'b0;
    unique case (op)
      OP_CLEAR: cnt_d = RST_V;
      OP_LOAD:  cnt_d = sat_load(load_value);
      OP_STEP: begin
        unique case (up_down)
          DIR_UP: begin
            if (cnt_q >= MAX_V) begin
              cnt_d = '0;
              wrap  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          DIR_DOWN: begin
            if (cnt_q == '0) begin
              cnt_d = MAX_V;
              wrap  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: cnt_d = cnt_q;
        endcase
      end
      default: cnt_d = cnt_q;
    endcase

    tc_d     = wrap;
    sticky_d = sticky_q;
    if (wrap_clr) begin
      sticky_d = 1'b0;
    end
    if (wrap) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q    <= RST_V;
      tc_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      sticky_q <= sticky_d;
    end
  end

  assign counting       = cnt_q;
  assign terminal_count = tc_q;
  assign wrap_sticky    = sticky_q;

endmodule
